issue_select_multi: RTL and testbench
=====================================

// Module: issue_select_multi
// PURPOSE
//  Parametrised N-wide issue stage between the reservation stations and execute.
//  Each cycle it selects up to ISSUE_W ready RS entries, oldest first, using an internal age matrix.
//  It forms the operands and registers them into per-lane issue/execute slots with a valid/ready handshake.
//  It returns a one-hot-per-entry grant vector so the RS can free issued entries.
// PARAMETERS
//  RS_SIZE    8   number of reservation-station entries
//  ISSUE_W    2   issue lanes (1..RS_SIZE)
//  DATA_W     32  operand / immediate width
//  TAG_W      5   ROB tag width; tag value 0 = operand available
//  CTRL_W     16  control-bit vector width
//  ALUSRC_BIT 0   ctrl bit index: 1 = B operand is immediate
//  MEMWR_BIT  1   ctrl bit index: 1 = store, data = value_2
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  reset      in   1                  asynchronous, active-low reset
//  flush      in   1                  sync squash of all lanes (mispredict)
//  alloc_vld  in   1                  RS entry allocated this cycle
//  alloc_idx  in   $clog2(RS_SIZE)    index of the allocated entry
//  rs_busy    in   RS_SIZE            entry valid
//  rs_tag_1   in   RS_SIZE*TAG_W      pending producer tag, operand 1
//  rs_tag_2   in   RS_SIZE*TAG_W      pending producer tag, operand 2
//  rs_value_1 in   RS_SIZE*DATA_W     operand 1 value
//  rs_value_2 in   RS_SIZE*DATA_W     operand 2 value
//  rs_imm     in   RS_SIZE*DATA_W     immediate
//  rs_ctrl    in   RS_SIZE*CTRL_W     control bits
//  rs_tag     in   RS_SIZE*TAG_W      destination ROB tag
//  grant      out  RS_SIZE            comb: entry issued this cycle; RS clears busy at next edge
//  iss_ready  in   ISSUE_W            execute lane accepts slot contents
//  iss_valid  out  ISSUE_W            lane slot holds an instruction
//  iss_srcA / iss_srcB / iss_data  out  ISSUE_W*DATA_W   lane operands
//  iss_ctrl   out  ISSUE_W*CTRL_W     lane control bits
//  iss_tag    out  ISSUE_W*TAG_W      lane destination tag
//  iss_rs_id  out  ISSUE_W*$clog2(RS_SIZE)  source RS index
// BEHAVIOUR
//  - Reset (reset=0, async): all iss_* outputs 0, age matrix all 0. grant is 0 while reset is low.
//  - Entry i is ready when rs_busy[i] is set and both rs_tag_1[i] and rs_tag_2[i] are 0.
//  - Age: older[i][j]=1 means i is older than j.
//    On alloc_vld, set older[alloc_idx][*]=0 and older[*][alloc_idx]=1 (new entry is youngest).
//  - Tie-break: i beats j if older[i][j], or if (!older[j][i] and i<j), i.e. lower index wins on equal age.
//  - Lane free = !iss_valid[l] || iss_ready[l].
//    Free lanes are filled in ascending lane order with the oldest-first ready entries not already chosen.
//    Each entry is granted to at most one lane.
//  - Stalled lane (valid && !ready) holds every output unchanged, takes no entry, and leaves the other lanes unaffected.
//  - Free lane with no candidate: iss_valid[l] goes to 0 at the next edge; the other outputs keep their old values.
//  - Operand forming:
//    - srcA = value_1.
//    - srcB = ctrl[ALUSRC_BIT] ? imm : value_2.
//    - data = ctrl[MEMWR_BIT] ? value_2 : 0.
//  - Latency: an entry that is ready in cycle t appears on iss_* in cycle t+1 (one registered stage). grant is asserted in cycle t.
//  - flush=1: grant=0 that cycle; all iss_valid go to 0 at the next edge. Age matrix is retained. flush overrides iss_ready.
//  - alloc and select in the same cycle: the newly allocated entry cannot be ready that cycle (RS writes at the edge).
//    The age update and selection both use pre-edge state.
//  - ISSUE_W > number of ready entries: the extra lanes go idle. All entries not ready: grant=0.
// TESTING
//  1. Reset low mid-run with lanes valid -> iss_valid=0 and grant=0 immediately; after release, idle until an entry is ready.
//  2. Allocate entries 5,2,7 in that order, all ready, ISSUE_W=2 -> cycle1 grant=8'b0010_0100, lane0 rs_id=5, lane1 rs_id=2; next cycle lane0 rs_id=7.
//  3. Entry 3 with alusrc=1, imm=0x10, value_2=0x99, memwr=1 -> srcB=0x10, data=0x99, tag matches rs_tag[3].
//  4. iss_ready[0]=0 for 3 cycles with 4 ready entries -> lane0 outputs stable; lane1 issues one entry per cycle oldest-first; no duplicate grants.
//  5. Entry 1 with rs_tag_2=4 -> never granted; once the tag clears to 0 it issues the following cycle.
//  6. flush with both lanes valid and 2 entries ready -> grant=0, iss_valid=00 next cycle, then issue resumes in oldest-first order.

Source files
------------

// File: rtl/issue_select_multi_if.sv
// Purpose : bundles the RS-side request bus and the per-lane issue/execute bus of the issue stage.
// Latency : n/a (wiring only).
// Backpressure: iss_ready per lane, driven by execute; grant is returned to the RS in the same cycle.
// Ports   : master = issue stage (drives grant and iss_*), slave = RS + execute environment.
interface issue_select_multi_if #(
  parameter int RS_SIZE = 8,
  parameter int ISSUE_W = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int CTRL_W  = 16
);
  localparam int IDX_W = $clog2(RS_SIZE);

  // reservation-station side
  logic                        flush;
  logic                        alloc_vld;
  logic [IDX_W-1:0]            alloc_idx;
  logic [RS_SIZE-1:0]          rs_busy;
  logic [RS_SIZE*TAG_W-1:0]    rs_tag_1;
  logic [RS_SIZE*TAG_W-1:0]    rs_tag_2;
  logic [RS_SIZE*DATA_W-1:0]   rs_value_1;
  logic [RS_SIZE*DATA_W-1:0]   rs_value_2;
  logic [RS_SIZE*DATA_W-1:0]   rs_imm;
  logic [RS_SIZE*CTRL_W-1:0]   rs_ctrl;
  logic [RS_SIZE*TAG_W-1:0]    rs_tag;
  logic [RS_SIZE-1:0]          grant;

  // execute side
  logic [ISSUE_W-1:0]          iss_ready;
  logic [ISSUE_W-1:0]          iss_valid;
  logic [ISSUE_W*DATA_W-1:0]   iss_srcA;
  logic [ISSUE_W*DATA_W-1:0]   iss_srcB;
  logic [ISSUE_W*DATA_W-1:0]   iss_data;
  logic [ISSUE_W*CTRL_W-1:0]   iss_ctrl;
  logic [ISSUE_W*TAG_W-1:0]    iss_tag;
  logic [ISSUE_W*IDX_W-1:0]    iss_rs_id;

  modport master (
    input  flush, alloc_vld, alloc_idx, rs_busy, rs_tag_1, rs_tag_2,
           rs_value_1, rs_value_2, rs_imm, rs_ctrl, rs_tag, iss_ready,
    output grant, iss_valid, iss_srcA, iss_srcB, iss_data, iss_ctrl,
           iss_tag, iss_rs_id
  );

  modport slave (
    output flush, alloc_vld, alloc_idx, rs_busy, rs_tag_1, rs_tag_2,
           rs_value_1, rs_value_2, rs_imm, rs_ctrl, rs_tag, iss_ready,
    input  grant, iss_valid, iss_srcA, iss_srcB, iss_data, iss_ctrl,
           iss_tag, iss_rs_id
  );
endinterface

// File: rtl/issue_select_multi.sv
// Purpose : N-wide oldest-first issue select from the RS into registered per-lane execute slots.
// Latency : grant is combinational in cycle t; the entry appears on iss_* in cycle t+1.
// Backpressure: a lane with iss_valid && !iss_ready holds its slot and takes nothing; flush drops all slots.
// Ports   : clk, reset (async active-low), bus (issue_select_multi_if.master: RS inputs, grant,
//           per-lane iss_ready in, iss_valid/srcA/srcB/data/ctrl/tag/rs_id out).
module issue_select_multi #(
  parameter int RS_SIZE    = 8,
  parameter int ISSUE_W    = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int CTRL_W     = 16,
  parameter int ALUSRC_BIT = 0,
  parameter int MEMWR_BIT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  issue_select_multi_if.master bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  // per-entry views of the flat RS buses
  logic [RS_SIZE-1:0][TAG_W-1:0]  tag_1, tag_2, dst_tag;
  logic [RS_SIZE-1:0][DATA_W-1:0] value_1, value_2, imm;
  logic [RS_SIZE-1:0][CTRL_W-1:0] ctrl;

  assign tag_1   = bus.rs_tag_1;
  assign tag_2   = bus.rs_tag_2;
  assign dst_tag = bus.rs_tag;
  assign value_1 = bus.rs_value_1;
  assign value_2 = bus.rs_value_2;
  assign imm     = bus.rs_imm;
  assign ctrl    = bus.rs_ctrl;

  // older_q[i][j] = 1 : entry i is older than entry j
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;

  logic [ISSUE_W-1:0]             valid_q, valid_d;
  logic [ISSUE_W-1:0][DATA_W-1:0] src_a_q, src_a_d;
  logic [ISSUE_W-1:0][DATA_W-1:0] src_b_q, src_b_d;
  logic [ISSUE_W-1:0][DATA_W-1:0] data_q, data_d;
  logic [ISSUE_W-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [ISSUE_W-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ISSUE_W-1:0][IDX_W-1:0]  rs_id_q, rs_id_d;

  logic                           issue_en;
  logic [RS_SIZE-1:0]             ready;
  logic [RS_SIZE-1:0]             taken;
  logic [ISSUE_W-1:0]             lane_free;
  logic [ISSUE_W-1:0]             lane_hit;
  logic [ISSUE_W-1:0][IDX_W-1:0]  lane_sel;

  // grant must read 0 while reset is held, even though the RS may still show ready entries
  assign issue_en = reset && !bus.flush;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = bus.rs_busy[i] && (tag_1[i] == '0) && (tag_2[i] == '0);
    end
  end

  // Lanes are filled in ascending order; each lane scans the ready entries not yet
  // claimed by a lower lane and keeps the winner of a pairwise oldest-first compare.
  always_comb begin
    taken     = '0;
    lane_free = '0;
    lane_hit  = '0;
    lane_sel  = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      lane_free[l] = !valid_q[l] || bus.iss_ready[l];
      if (issue_en && lane_free[l]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ready[i] && !taken[i]) begin
            // i beats the current pick if older, or equal age and lower index
            if (!lane_hit[l] ||
                older_q[i][lane_sel[l]] ||
                (!older_q[lane_sel[l]][i] && (IDX_W'(i) < lane_sel[l]))) begin
              lane_hit[l] = 1'b1;
              lane_sel[l] = IDX_W'(i);
            end
          end
        end
        if (lane_hit[l]) begin
          taken[lane_sel[l]] = 1'b1;
        end
      end
    end
  end

  assign bus.grant = taken;

  // Slot next-state: stalled lanes hold, free lanes load or go idle, flush drops everything.
  always_comb begin
    valid_d = valid_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    rs_id_d = rs_id_q;
    for (int l = 0; l < ISSUE_W; l++) begin
      if (bus.flush) begin
        valid_d[l] = 1'b0;
      end else if (lane_free[l]) begin
        valid_d[l] = lane_hit[l];
        if (lane_hit[l]) begin
          src_a_d[l] = value_1[lane_sel[l]];
          src_b_d[l] = ctrl[lane_sel[l]][ALUSRC_BIT] ? imm[lane_sel[l]] : value_2[lane_sel[l]];
          data_d[l]  = ctrl[lane_sel[l]][MEMWR_BIT] ? value_2[lane_sel[l]] : '0;
          ctrl_d[l]  = ctrl[lane_sel[l]];
          tag_d[l]   = dst_tag[lane_sel[l]];
          rs_id_d[l] = lane_sel[l];
        end
      end
    end
  end

  // A newly allocated entry becomes the youngest: it is older than nobody and
  // every other entry is older than it. The diagonal is kept at 0.
  always_comb begin
    older_d = older_q;
    if (bus.alloc_vld) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        older_d[bus.alloc_idx][j] = 1'b0;
        older_d[j][bus.alloc_idx] = (IDX_W'(j) != bus.alloc_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      older_q <= '0;
      valid_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      tag_q   <= '0;
      rs_id_q <= '0;
    end else begin
      older_q <= older_d;
      valid_q <= valid_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      tag_q   <= tag_d;
      rs_id_q <= rs_id_d;
    end
  end

  assign bus.iss_valid = valid_q;
  assign bus.iss_srcA  = src_a_q;
  assign bus.iss_srcB  = src_b_q;
  assign bus.iss_data  = data_q;
  assign bus.iss_ctrl  = ctrl_q;
  assign bus.iss_tag   = tag_q;
  assign bus.iss_rs_id = rs_id_q;
endmodule

// File: tb/tb_issue_select_multi.sv
// Bench for issue_select_multi: directed RS scenarios, an allocation-order reference
// model compared every cycle, and literal expectations at the key points of each scenario.
module tb_issue_select_multi;
  localparam int RS = 8;
  localparam int IW = 2;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_select_multi_if #(.RS_SIZE(RS), .ISSUE_W(IW), .DATA_W(DW), .TAG_W(TW), .CTRL_W(CW)) bus ();

  issue_select_multi #(.RS_SIZE(RS), .ISSUE_W(IW), .DATA_W(DW), .TAG_W(TW), .CTRL_W(CW),
                       .ALUSRC_BIT(0), .MEMWR_BIT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: age is an allocation sequence number (0 = never allocated since reset,
  // which ranks oldest); ties go to the lower index. Lane slots are plain registers.
  int             stamp [RS];
  int             n_stamp [RS];
  int             stamp_ctr = 0;
  logic [IW-1:0]  m_valid, n_valid;
  logic [DW-1:0]  m_srca [IW], m_srcb [IW], m_data [IW];
  logic [DW-1:0]  n_srca [IW], n_srcb [IW], n_data [IW];
  logic [CW-1:0]  m_ctrl [IW], n_ctrl [IW];
  logic [TW-1:0]  m_tag [IW], n_tag [IW];
  logic [2:0]     m_rsid [IW], n_rsid [IW];
  logic [RS-1:0]  seen_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit entry_ready(int i);
    return bus.rs_busy[i] && (bus.rs_tag_1[i*TW +: TW] == 0) && (bus.rs_tag_2[i*TW +: TW] == 0);
  endfunction

  task automatic model_reset();
    m_valid = '0;
    for (int l = 0; l < IW; l++) begin
      m_srca[l] = '0; m_srcb[l] = '0; m_data[l] = '0;
      m_ctrl[l] = '0; m_tag[l] = '0; m_rsid[l] = '0;
    end
    for (int i = 0; i < RS; i++) stamp[i] = 0;
  endtask

  // Compare at the falling edge, then work out the model state after the next rising edge.
  task automatic sample();
    int            pick [IW];
    bit            free [IW];
    logic [RS-1:0] eg;
    logic [CW-1:0] c;
    logic [DW-1:0] v2;
    @(negedge clk);
    if (!reset) model_reset();
    eg = '0;
    for (int l = 0; l < IW; l++) begin
      pick[l] = -1;
      free[l] = !m_valid[l] || bus.iss_ready[l];
      if (reset && !bus.flush && free[l]) begin
        for (int i = 0; i < RS; i++)
          if (entry_ready(i) && !eg[i] && (pick[l] < 0 || stamp[i] < stamp[pick[l]])) pick[l] = i;
        if (pick[l] >= 0) eg[pick[l]] = 1'b1;
      end
    end
    chk("grant", 64'(bus.grant), 64'(eg));
    for (int l = 0; l < IW; l++) begin
      chk($sformatf("valid%0d", l), 64'(bus.iss_valid[l]), 64'(m_valid[l]));
      chk($sformatf("srcA%0d", l), 64'(bus.iss_srcA[l*DW +: DW]), 64'(m_srca[l]));
      chk($sformatf("srcB%0d", l), 64'(bus.iss_srcB[l*DW +: DW]), 64'(m_srcb[l]));
      chk($sformatf("data%0d", l), 64'(bus.iss_data[l*DW +: DW]), 64'(m_data[l]));
      chk($sformatf("ctrl%0d", l), 64'(bus.iss_ctrl[l*CW +: CW]), 64'(m_ctrl[l]));
      chk($sformatf("tag%0d", l), 64'(bus.iss_tag[l*TW +: TW]), 64'(m_tag[l]));
      chk($sformatf("rsid%0d", l), 64'(bus.iss_rs_id[l*3 +: 3]), 64'(m_rsid[l]));
    end
    seen_grant = bus.grant;
    n_valid = m_valid; n_srca = m_srca; n_srcb = m_srcb; n_data = m_data;
    n_ctrl = m_ctrl; n_tag = m_tag; n_rsid = m_rsid; n_stamp = stamp;
    if (reset) begin
      for (int l = 0; l < IW; l++) begin
        if (bus.flush) n_valid[l] = 1'b0;
        else if (free[l]) begin
          n_valid[l] = (pick[l] >= 0);
          if (pick[l] >= 0) begin
            c  = bus.rs_ctrl[pick[l]*CW +: CW];
            v2 = bus.rs_value_2[pick[l]*DW +: DW];
            n_srca[l] = bus.rs_value_1[pick[l]*DW +: DW];
            n_srcb[l] = c[0] ? bus.rs_imm[pick[l]*DW +: DW] : v2;
            n_data[l] = c[1] ? v2 : '0;
            n_ctrl[l] = c;
            n_tag[l]  = bus.rs_tag[pick[l]*TW +: TW];
            n_rsid[l] = 3'(pick[l]);
          end
        end
      end
      if (bus.alloc_vld) begin
        stamp_ctr++;
        n_stamp[bus.alloc_idx] = stamp_ctr;
      end
    end
  endtask

  // Step past the rising edge; the RS frees whatever was granted.
  task automatic advance();
    @(posedge clk);
    #1;
    m_valid = n_valid; m_srca = n_srca; m_srcb = n_srcb; m_data = n_data;
    m_ctrl = n_ctrl; m_tag = n_tag; m_rsid = n_rsid; stamp = n_stamp;
    bus.rs_busy = bus.rs_busy & ~seen_grant;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin sample(); advance(); end
  endtask

  task automatic set_fields(input int i, input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                            input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                            input logic [DW-1:0] im, input logic [CW-1:0] c,
                            input logic [TW-1:0] dt);
    bus.rs_tag_1[i*TW +: TW]   = t1;
    bus.rs_tag_2[i*TW +: TW]   = t2;
    bus.rs_value_1[i*DW +: DW] = v1;
    bus.rs_value_2[i*DW +: DW] = v2;
    bus.rs_imm[i*DW +: DW]     = im;
    bus.rs_ctrl[i*CW +: CW]    = c;
    bus.rs_tag[i*TW +: TW]     = dt;
  endtask

  task automatic set_tag2(input int i, input logic [TW-1:0] t);
    bus.rs_tag_2[i*TW +: TW] = t;
  endtask

  // Allocation cycle: the RS writes the entry at the edge, so it is busy only afterwards.
  task automatic alloc_entry(input int i, input logic [TW-1:0] t2);
    set_fields(i, '0, t2, DW'(32'h100 + i), DW'(32'h200 + i), DW'(32'h300 + i), '0, TW'(16 + i));
    bus.alloc_vld = 1'b1;
    bus.alloc_idx = 3'(i);
    sample();
    advance();
    bus.rs_busy[i] = 1'b1;
    bus.alloc_vld  = 1'b0;
  endtask

  task automatic lane_id(input string name, input int l, input int id);
    chk(name, 64'(bus.iss_rs_id[l*3 +: 3]), 64'(id));
  endtask

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0; bus.alloc_vld = 1'b0; bus.alloc_idx = '0;
    bus.rs_busy = '0; bus.rs_tag_1 = '0; bus.rs_tag_2 = '0;
    bus.rs_value_1 = '0; bus.rs_value_2 = '0; bus.rs_imm = '0;
    bus.rs_ctrl = '0; bus.rs_tag = '0; bus.iss_ready = 2'b11;
    model_reset();

    // reset state
    sample();
    chk("rst_valid", 64'(bus.iss_valid), 64'(0));
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_srcA", 64'(bus.iss_srcA), 64'(0));
    advance();
    idle(1);
    reset = 1'b1;
    idle(2);

    // allocate 5,2,7 with a pending operand, then release all together
    alloc_entry(5, 5'd1);
    alloc_entry(2, 5'd1);
    alloc_entry(7, 5'd1);
    set_tag2(5, '0); set_tag2(2, '0); set_tag2(7, '0);
    sample();
    chk("age_grant1", 64'(bus.grant), 64'h24);
    advance();
    sample();
    lane_id("age_l0_id5", 0, 5);
    lane_id("age_l1_id2", 1, 2);
    chk("age_valid11", 64'(bus.iss_valid), 64'(2'b11));
    chk("age_grant2", 64'(bus.grant), 64'h80);
    chk("age_srcB_l0", 64'(bus.iss_srcB[DW-1:0]), 64'h205);
    advance();
    sample();
    lane_id("age_l0_id7", 0, 7);
    chk("age_valid01", 64'(bus.iss_valid), 64'(2'b01));
    advance();
    idle(1);

    // operand forming: immediate B, store data = value_2
    set_fields(3, '0, '0, 32'h33, 32'h99, 32'h10, 16'h0003, 5'h0B);
    bus.alloc_vld = 1'b1; bus.alloc_idx = 3'd3;
    sample(); advance();
    bus.rs_busy[3] = 1'b1; bus.alloc_vld = 1'b0;
    sample();
    chk("op_grant", 64'(bus.grant), 64'h08);
    advance();
    sample();
    chk("op_srcA", 64'(bus.iss_srcA[DW-1:0]), 64'h33);
    chk("op_srcB", 64'(bus.iss_srcB[DW-1:0]), 64'h10);
    chk("op_data", 64'(bus.iss_data[DW-1:0]), 64'h99);
    chk("op_tag", 64'(bus.iss_tag[TW-1:0]), 64'h0B);
    advance();
    idle(2);

    // lane 0 stalled, lane 1 drains oldest-first
    alloc_entry(0, 5'd1); alloc_entry(1, 5'd1); alloc_entry(4, 5'd1); alloc_entry(6, 5'd1);
    bus.iss_ready = 2'b10;
    set_tag2(0, '0); set_tag2(1, '0); set_tag2(4, '0); set_tag2(6, '0);
    sample();
    chk("stall_grant1", 64'(bus.grant), 64'h03);
    advance();
    sample();
    lane_id("stall_l0_a", 0, 0); lane_id("stall_l1_a", 1, 1);
    chk("stall_grant2", 64'(bus.grant), 64'h10);
    advance();
    sample();
    lane_id("stall_l0_b", 0, 0); lane_id("stall_l1_b", 1, 4);
    chk("stall_grant3", 64'(bus.grant), 64'h40);
    advance();
    sample();
    lane_id("stall_l0_c", 0, 0); lane_id("stall_l1_c", 1, 6);
    chk("stall_grant4", 64'(bus.grant), 64'h00);
    advance();
    sample();
    lane_id("stall_l0_d", 0, 0);
    chk("stall_valid01", 64'(bus.iss_valid), 64'(2'b01));
    advance();
    bus.iss_ready = 2'b11;
    idle(2);

    // pending operand blocks issue until its tag clears
    alloc_entry(1, 5'd4);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("dep_grant_blocked", 64'(bus.grant), 64'h00);
      advance();
    end
    set_tag2(1, '0);
    sample();
    chk("dep_grant", 64'(bus.grant), 64'h02);
    advance();
    sample();
    lane_id("dep_l0_id1", 0, 1);
    advance();
    idle(1);

    // flush with both lanes busy and two more entries ready
    alloc_entry(3, 5'd1); alloc_entry(0, 5'd1); alloc_entry(6, 5'd1); alloc_entry(7, 5'd1);
    set_tag2(3, '0); set_tag2(0, '0); set_tag2(6, '0); set_tag2(7, '0);
    sample();
    chk("fl_grant_pre", 64'(bus.grant), 64'h09);
    advance();
    bus.flush = 1'b1;
    sample();
    chk("fl_grant0", 64'(bus.grant), 64'h00);
    chk("fl_valid11", 64'(bus.iss_valid), 64'(2'b11));
    advance();
    bus.flush = 1'b0;
    bus.iss_ready = 2'b00;
    sample();
    chk("fl_valid00", 64'(bus.iss_valid), 64'(2'b00));
    chk("fl_grant_resume", 64'(bus.grant), 64'hC0);
    advance();
    sample();
    lane_id("fl_l0_id6", 0, 6); lane_id("fl_l1_id7", 1, 7);
    advance();

    // reset asserted mid-run with valid lanes and a grantable entry
    alloc_entry(4, '0);
    bus.iss_ready = 2'b01;
    #1;
    chk("mid_pre_grant", 64'(bus.grant), 64'h10);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.iss_valid), 64'(0));
    chk("mid_rst_grant", 64'(bus.grant), 64'(0));
    bus.rs_busy = '0;
    bus.iss_ready = 2'b11;
    idle(2);
    reset = 1'b1;
    idle(1);
    sample();
    chk("post_rst_idle", 64'(bus.iss_valid), 64'(0));
    advance();

    // equal age after reset: lower index wins
    bus.rs_busy[6] = 1'b1; bus.rs_busy[1] = 1'b1;
    sample();
    chk("tie_grant", 64'(bus.grant), 64'h42);
    advance();
    sample();
    lane_id("tie_l0_id1", 0, 1); lane_id("tie_l1_id6", 1, 6);
    advance();
    idle(1);

    // one ready entry, two lanes: lane 1 idles
    alloc_entry(4, '0);
    sample();
    chk("one_grant", 64'(bus.grant), 64'h10);
    advance();
    sample();
    lane_id("one_l0_id4", 0, 4);
    chk("one_valid01", 64'(bus.iss_valid), 64'(2'b01));
    advance();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
